// File: rtl/digital_front_end.sv
// digital_front_end
//   Per-pixel front end: synchronises the discriminator outputs, arbitrates
//   local hits against the four neighbours in charge-summing mode, emits
//   hitPulse/sumPulse and counts them in two independently shuttered
//   counters. With its shutter low a counter becomes one stage of a
//   daisy-chained shift register (SerIn -> cnt -> SerOut).
// Ports
//   clk_read, reset          : clock, synchronous active-high reset
//   SummingMode              : 1 = charge-summing arbitration, 0 = single pixel
//   discOutLocal             : local discriminator (async)
//   discOutNeighbour[3:0]    : neighbour discriminators (async), [3:2] outrank local
//   ackFromNeighbour[3:0]    : neighbour claim flags (clk_read domain)
//   ackToNeighbour[3:0]      : local claim flag, replicated
//   discOutSumLocal          : local summed-charge discriminator (async)
//   discOutSumNeighbour[2:0] : neighbour summed-charge discriminators (async)
//   hitPulse, sumPulse       : one-cycle event pulses
//   shutterA/B               : 1 = count, 0 = shift
//   SerInA/B, SerOutA/B      : serial chain in / out (out = counter MSB)
module digital_front_end #(
  parameter int unsigned CNT_W = 12
) (
  input  logic       clk_read,
  input  logic       reset,
  input  logic       SummingMode,
  input  logic       discOutLocal,
  input  logic [3:0] discOutNeighbour,
  input  logic [3:0] ackFromNeighbour,
  output logic [3:0] ackToNeighbour,
  input  logic       discOutSumLocal,
  input  logic [2:0] discOutSumNeighbour,
  output logic       hitPulse,
  output logic       sumPulse,
  input  logic       shutterA,
  input  logic       shutterB,
  input  logic       SerInA,
  input  logic       SerInB,
  output logic       SerOutA,
  output logic       SerOutB
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK_PEND,   // claimed, sumPulse still owed
    ST_ACK_DONE    // claimed, sumPulse already issued
  } state_e;

  // Bit layout: [0] local, [4:1] neighbours, [5] sum local, [8:6] sum neighbours
  logic [8:0] async_in;
  logic [8:0] s1_q, s2_q;
  // Only the edge-detected inputs (local + neighbours) need the history flop.
  logic [4:0] s3_q;

  state_e state_q, state_d;
  logic hit_q, hit_d;
  logic sum_q, sum_d;
  logic ack_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  logic       loc_s2, loc_rise, sum_active, block, claim, src_b;
  logic [3:0] nb_s2, nb_s3;

  assign async_in = {discOutSumNeighbour, discOutSumLocal, discOutNeighbour, discOutLocal};

  assign loc_s2     = s2_q[0];
  assign loc_rise   = s2_q[0] & ~s3_q[0];
  assign nb_s2      = s2_q[4:1];
  assign nb_s3      = s3_q[4:1];
  assign sum_active = s2_q[5] | (|s2_q[8:6]);

  // Blocked by an existing neighbour claim, a neighbour event already in
  // progress, or a simultaneous rise on a higher-priority neighbour.
  assign block = (|ackFromNeighbour) | (|(nb_s2 & nb_s3)) | (|(nb_s2[3:2] & ~nb_s3[3:2]));
  assign claim = loc_rise & ~block;

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    sum_d   = 1'b0;
    if (!SummingMode) begin
      hit_d   = loc_rise;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (claim) begin
            hit_d   = 1'b1;
            sum_d   = sum_active;
            state_d = sum_active ? ST_ACK_DONE : ST_ACK_PEND;
          end
        end
        ST_ACK_PEND: begin
          sum_d = sum_active;
          if (!loc_s2)         state_d = ST_IDLE;
          else if (sum_active) state_d = ST_ACK_DONE;
        end
        ST_ACK_DONE: begin
          if (!loc_s2) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic shutter,
                                                input logic inc,
                                                input logic ser);
    if (!shutter)             return {cnt[CNT_W-2:0], ser};
    if (inc && (cnt != '1))   return cnt + CNT_W'(1);
    return cnt;
  endfunction

  assign src_b = SummingMode ? sum_q : hit_q;

  always_ff @(posedge clk_read) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      state_q <= ST_IDLE;
      hit_q   <= 1'b0;
      sum_q   <= 1'b0;
      ack_q   <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      s1_q    <= async_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q[4:0];
      state_q <= state_d;
      hit_q   <= hit_d;
      sum_q   <= sum_d;
      ack_q   <= (state_d != ST_IDLE);
      cnt_a_q <= cnt_next(cnt_a_q, shutterA, hit_q, SerInA);
      cnt_b_q <= cnt_next(cnt_b_q, shutterB, src_b, SerInB);
    end
  end

  assign hitPulse       = hit_q;
  assign sumPulse       = sum_q;
  assign ackToNeighbour = {4{ack_q}};
  assign SerOutA        = cnt_a_q[CNT_W-1];
  assign SerOutB        = cnt_b_q[CNT_W-1];

endmodule

// File: tb/tb_digital_front_end.sv
// tb_digital_front_end
//   Self-checking bench for digital_front_end: a per-cycle reference model
//   built from per-edge input history, a table of arbitration vectors, and
//   hand-written multi-cycle sequences (latency, deferred sum, saturation,
//   serial readout).
module tb_digital_front_end;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] MAXC = '1;

  logic       clk_read = 1'b0;
  logic       reset = 1'b0;
  logic       SummingMode = 1'b0;
  logic       discOutLocal = 1'b0;
  logic [3:0] discOutNeighbour = '0;
  logic [3:0] ackFromNeighbour = '0;
  logic [3:0] ackToNeighbour;
  logic       discOutSumLocal = 1'b0;
  logic [2:0] discOutSumNeighbour = '0;
  logic       hitPulse, sumPulse;
  logic       shutterA = 1'b1, shutterB = 1'b1;
  logic       SerInA = 1'b0, SerInB = 1'b0;
  logic       SerOutA, SerOutB;

  digital_front_end #(.CNT_W(CNT_W)) dut (
    .clk_read(clk_read), .reset(reset), .SummingMode(SummingMode),
    .discOutLocal(discOutLocal), .discOutNeighbour(discOutNeighbour),
    .ackFromNeighbour(ackFromNeighbour), .ackToNeighbour(ackToNeighbour),
    .discOutSumLocal(discOutSumLocal), .discOutSumNeighbour(discOutSumNeighbour),
    .hitPulse(hitPulse), .sumPulse(sumPulse),
    .shutterA(shutterA), .shutterB(shutterB),
    .SerInA(SerInA), .SerInB(SerInB), .SerOutA(SerOutA), .SerOutB(SerOutB)
  );

  always #5 clk_read = ~clk_read;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[n] = async inputs as present at edge n: {sn[2:0], sl, nb[3:0], loc}.
  // A synchronised (s2) value seen just before edge n is the input of edge n-2.
  localparam int HMAX = 32768;
  logic [8:0] hist [0:HMAX-1];
  int  n = 0;
  int  last_rst = -1;
  bit  armed = 0;
  logic m_hit = 0, m_sum = 0, m_win = 0, m_pend = 0;
  logic [CNT_W-1:0] m_a = '0, m_b = '0;

  function automatic logic [8:0] hv(input int k);
    if (k <= last_rst || k < 0) return '0;
    return hist[k];
  endfunction

  always @(posedge clk_read) begin
    logic [8:0] p, q;
    logic rise, sact, blocked, ph, ps;
    #1;
    n++;
    if (n < HMAX) hist[n] = {discOutSumNeighbour, discOutSumLocal, discOutNeighbour, discOutLocal};
    if (reset) begin
      armed = 1; last_rst = n;
      m_hit = 0; m_sum = 0; m_win = 0; m_pend = 0; m_a = '0; m_b = '0;
    end else if (armed) begin
      p = hv(n - 2);  // synchronised level before this edge
      q = hv(n - 3);  // one cycle older
      rise = p[0] && !q[0];
      sact = p[5] || (p[8:6] != 0);
      blocked = (ackFromNeighbour != 0) || ((p[4:1] & q[4:1]) != 0) ||
                ((p[4:3] & ~q[4:3]) != 0);
      ph = m_hit; ps = m_sum;
      m_hit = 0; m_sum = 0;
      if (!SummingMode) begin
        m_hit = rise; m_win = 0; m_pend = 0;
      end else if (m_win) begin
        if (m_pend && sact) m_sum = 1;
        m_pend = m_pend && !sact && p[0];
        m_win  = p[0];
      end else if (rise && !blocked) begin
        m_hit = 1; m_sum = sact; m_win = 1; m_pend = !sact;
      end
      if (shutterA) begin if (ph && m_a != MAXC) m_a = m_a + 1; end
      else m_a = {m_a[CNT_W-2:0], SerInA};
      if (shutterB) begin if ((SummingMode ? ps : ph) && m_b != MAXC) m_b = m_b + 1; end
      else m_b = {m_b[CNT_W-2:0], SerInB};
    end
    if (armed) begin
      chk("m_hitPulse", hitPulse, m_hit);
      chk("m_sumPulse", sumPulse, m_sum);
      chk("m_ack", ackToNeighbour, m_win ? 4'hF : 4'h0);
      chk("m_cntA", dut.cnt_a_q, m_a);
      chk("m_cntB", dut.cnt_b_q, m_b);
      chk("m_SerOutA", SerOutA, m_a[CNT_W-1]);
      chk("m_SerOutB", SerOutB, m_b[CNT_W-1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk_read);
      #2;
    end
  endtask

  task automatic quiet();
    discOutLocal = 0; discOutNeighbour = '0; ackFromNeighbour = '0;
    discOutSumLocal = 0; discOutSumNeighbour = '0;
    SerInA = 0; SerInB = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step(2);
    reset = 0;
  endtask

  typedef struct {
    string      name;
    logic       mode;
    logic [3:0] pre_nb;
    logic [3:0] nb;
    logic [3:0] ackf;
    logic       sl;
    logic [2:0] sn;
    logic       e_hit;
    logic       e_sum;
    logic [3:0] e_ack;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int hits, sums, acks;
    logic [CNT_W-1:0] pat;

    vecs.push_back('{"alone_sum",   1, 4'h0, 4'h0, 4'h0, 1, 3'b000, 1, 1, 4'hF});
    vecs.push_back('{"ackfrom_blk", 1, 4'h0, 4'h0, 4'h1, 1, 3'b000, 0, 0, 4'h0});
    vecs.push_back('{"nb3_rise",    1, 4'h0, 4'h8, 4'h0, 1, 3'b000, 0, 0, 4'h0});
    vecs.push_back('{"nb2_rise",    1, 4'h0, 4'h4, 4'h0, 0, 3'b000, 0, 0, 4'h0});
    vecs.push_back('{"nb0_rise",    1, 4'h0, 4'h1, 4'h0, 0, 3'b000, 1, 0, 4'hF});
    vecs.push_back('{"nb1_inprog",  1, 4'h2, 4'h0, 4'h0, 1, 3'b000, 0, 0, 4'h0});
    vecs.push_back('{"sum_nb",      1, 4'h0, 4'h0, 4'h0, 0, 3'b010, 1, 1, 4'hF});
    vecs.push_back('{"single_mode", 0, 4'h0, 4'h8, 4'hF, 1, 3'b111, 1, 0, 4'h0});

    // Reset with random inputs
    SummingMode = 1'($urandom); discOutLocal = 1'($urandom);
    discOutNeighbour = 4'($urandom); ackFromNeighbour = 4'($urandom);
    discOutSumLocal = 1'($urandom); discOutSumNeighbour = 3'($urandom);
    shutterA = 1'($urandom); shutterB = 1'($urandom);
    SerInA = 1'($urandom); SerInB = 1'($urandom);
    do_reset();
    chk("rst_hit", hitPulse, 0);
    chk("rst_sum", sumPulse, 0);
    chk("rst_ack", ackToNeighbour, 0);
    chk("rst_serA", SerOutA, 0);
    chk("rst_serB", SerOutB, 0);
    chk("rst_cntA", dut.cnt_a_q, 0);
    chk("rst_cntB", dut.cnt_b_q, 0);

    // Single-pixel mode, 5 pulses
    quiet(); SummingMode = 0; shutterA = 1; shutterB = 1;
    do_reset();
    hits = 0; sums = 0; acks = 0;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 6; c++) begin
        discOutLocal = (c < 3);
        step();
        hits += int'(hitPulse); sums += int'(sumPulse); acks += int'(ackToNeighbour != 0);
      end
    end
    discOutLocal = 0;
    step(3);
    chk("sp_hits", hits, 5);
    chk("sp_sums", sums, 0);
    chk("sp_acks", acks, 0);
    chk("sp_cntA", dut.cnt_a_q, 5);
    chk("sp_cntB", dut.cnt_b_q, 5);

    // Arbitration table
    foreach (vecs[i]) begin
      quiet(); SummingMode = vecs[i].mode;
      step(5);
      discOutNeighbour = vecs[i].pre_nb;
      step(4);
      discOutLocal = 1; discOutNeighbour = vecs[i].pre_nb | vecs[i].nb;
      ackFromNeighbour = vecs[i].ackf;
      discOutSumLocal = vecs[i].sl; discOutSumNeighbour = vecs[i].sn;
      step(3);
      chk({vecs[i].name, "_hit"}, hitPulse, vecs[i].e_hit);
      chk({vecs[i].name, "_sum"}, sumPulse, vecs[i].e_sum);
      chk({vecs[i].name, "_ack"}, ackToNeighbour, vecs[i].e_ack);
      step();
      chk({vecs[i].name, "_hit_1cyc"}, hitPulse, 0);
    end

    // Deferred sumPulse within the ack window, then ack release
    quiet(); SummingMode = 1; shutterA = 1; shutterB = 1;
    do_reset();
    discOutLocal = 1;
    step(3);
    chk("def_hit", hitPulse, 1);
    chk("def_sum_early", sumPulse, 0);
    chk("def_ack", ackToNeighbour, 4'hF);
    discOutSumLocal = 1;
    step(3);
    chk("def_sum", sumPulse, 1);
    step();
    chk("def_sum_once", sumPulse, 0);
    discOutLocal = 0;
    step(2);
    chk("def_ack_held", ackToNeighbour, 4'hF);
    step();
    chk("def_ack_rel", ackToNeighbour, 4'h0);
    step(2);
    chk("def_cntA", dut.cnt_a_q, 1);
    chk("def_cntB", dut.cnt_b_q, 1);

    // Saturation
    quiet(); SummingMode = 0; shutterA = 0; shutterB = 1;
    do_reset();
    SerInA = 1;
    step(CNT_W);
    chk("sat_load", dut.cnt_a_q, MAXC);
    shutterA = 1; SerInA = 0;
    for (int p = 0; p < 3; p++) begin
      discOutLocal = 1; step(3);
      discOutLocal = 0; step(3);
    end
    step(3);
    chk("sat_cntA", dut.cnt_a_q, MAXC);
    chk("sat_cntB", dut.cnt_b_q, 3);

    // Serial readout of A while B counts
    quiet(); SummingMode = 0; shutterA = 0; shutterB = 1;
    do_reset();
    pat = 12'hA5C;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      SerInA = pat[i];
      step();
    end
    chk("sh_load", dut.cnt_a_q, pat);
    SerInA = 0;
    for (int i = 0; i < CNT_W; i++) begin
      chk($sformatf("sh_bit%0d", i), SerOutA, pat[CNT_W-1-i]);
      discOutLocal = ((i % 6) < 3);
      step();
    end
    chk("sh_clear", dut.cnt_a_q, 0);
    shutterA = 1; discOutLocal = 0;
    step(4);
    chk("sh_cntB", dut.cnt_b_q, 2);

    // Randomised run against the model
    quiet(); do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) discOutLocal = ~discOutLocal;
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) discOutNeighbour[b] = ~discOutNeighbour[b];
      if ($urandom_range(3) == 0) discOutSumLocal = ~discOutSumLocal;
      for (int b = 0; b < 3; b++) if ($urandom_range(5) == 0) discOutSumNeighbour[b] = ~discOutSumNeighbour[b];
      ackFromNeighbour = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
      SerInA = 1'($urandom); SerInB = 1'($urandom);
      if ($urandom_range(19) == 0) shutterA = ~shutterA;
      if ($urandom_range(19) == 0) shutterB = ~shutterB;
      if ($urandom_range(99) == 0) SummingMode = ~SummingMode;
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset = 0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digital_front_end.md
# digital_front_end

Per-pixel digital front end (module `digital_front_end`) of the photon-counting readout ASIC, clocked by `clk_read`, between the pixel's analog discriminators and the column's serial readout chain. It synchronises discriminator outputs and arbitrates hits against the four neighbour pixels in charge-summing mode. It produces hit and sum pulses and counts them in two independently shuttered counters, A and B, for continuous read-while-count. When a counter's shutter is low, that counter becomes a stage of a daisy-chained shift register.

## Interface
- `CNT_W`, default 12: width of counters A and B.
- `clk_read` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `SummingMode` in 1: 1 = charge-summing/arbitration mode, 0 = single-pixel mode.
- `discOutLocal` in 1: local pixel discriminator (asynchronous).
- `discOutNeighbour` in 4: neighbour discriminators (asynchronous). Bits [3:2] have priority over the local pixel; bits [1:0] have lower priority.
- `ackFromNeighbour` in 4: neighbour claim flags, already in the `clk_read` domain.
- `ackToNeighbour` out 4: local claim flag, replicated to all 4 neighbours.
- `discOutSumLocal` in 1: local summed-charge discriminator (asynchronous).
- `discOutSumNeighbour` in 3: neighbour summed-charge discriminators (asynchronous).
- `hitPulse` out 1: one-cycle pulse for each accepted local hit.
- `sumPulse` out 1: one-cycle pulse for each accepted summed event.
- `shutterA`, `shutterB` in 1: 1 = the counter counts; 0 = the counter shifts.
- `SerInA`, `SerInB` in 1: serial input from the previous pixel in the chain.
- `SerOutA`, `SerOutB` out 1: serial output; equals counter MSB.

## Operation
- Synchronisation:
  - Every asynchronous input passes through 2 flops (s1, s2). A third flop holds the previous s2 value (s3).
  - Rise is defined as s2 & ~s3.
  - Sum-active is defined as s2(discOutSumLocal) | any s2(discOutSumNeighbour).
- Single-pixel mode (SummingMode=0):
  - Every rise of discOutLocal is accepted and produces hitPulse.
  - ackToNeighbour = 0 and sumPulse = 0.
  - ackFromNeighbour and all neighbour inputs are ignored.
- Summing mode (SummingMode=1): a local rise is claimed only if none of these holds in the same cycle:
  - any ackFromNeighbour bit is 1;
  - any synchronised discOutNeighbour bit is high and was high the previous cycle (neighbour event already in progress);
  - discOutNeighbour[3] or [2] rises simultaneously.
- Simultaneous rises on neighbour bits [1:0] do not block the local claim.
- On a claim:
  - hitPulse fires.
  - ackToNeighbour becomes 4'b1111 and is held while s2(discOutLocal) stays high.
  - sumPulse fires once per claim: in the claim cycle if sum-active is 1, otherwise in the first later cycle of the ack window where sum-active is 1. If sum-active never becomes 1 during the window, there is no sumPulse.
- A rise that is not claimed produces no pulse and no ack.
- Count source:
  - Counter A counts hitPulse.
  - Counter B counts sumPulse when SummingMode=1, otherwise hitPulse.
- Counting (shutter=1):
  - The counter increments by 1 on each source pulse.
  - It saturates at 2^CNT_W−1 and never wraps.
- Shifting (shutter=0):
  - Every clk_read edge: cnt <= {cnt[CNT_W-2:0], SerIn}.
  - SerOut = cnt[CNT_W-1], driven straight from the flop.
  - Pulses arriving while the shutter is low are discarded.
  - The counter has no auto-clear; it is cleared by shifting in zeros from the chain head. The system gates clk_read, so exactly CNT_W shifts occur per readout.
- A and B are fully independent: one may count while the other shifts.
- SummingMode changes take effect at the next clock. An ack window in progress ends on the next clock if SummingMode drops.

## Timing
- Reset (synchronous, active-high, dominates): all synchroniser flops, counters, hitPulse, sumPulse, ackToNeighbour, SerOutA and SerOutB are 0 after the first edge with reset=1.
- Hit latency:
  - discOutLocal goes high before edge 1.
  - s1 = 1 after edge 1, s2 = 1 after edge 2.
  - hitPulse and ackToNeighbour are registered high after edge 3; hitPulse lasts exactly 1 cycle.
  - The counter shows the new value after edge 4.
- Ack release: ackToNeighbour is 0 on the edge after s2(discOutLocal) is sampled low.
- A new rise needs discOutLocal low for at least 1 synchronised cycle. At most 1 hitPulse and 1 sumPulse per rise.
- Shutter switches take effect at the edge where the shutter is sampled. A pulse coinciding with a falling-shutter edge is not counted.
- Reset asserted mid-count or mid-shift clears everything at that edge.

## Test plan
- Reset=1 for 2 cycles with random inputs → all outputs 0; counters 0.
- Single-pixel mode, shutterA=shutterB=1, 5 discOutLocal pulses (3 cycles high, 3 low) → 5 hitPulses, each 3 cycles after rise; A=B=5; ackToNeighbour=0; sumPulse=0.
- Summing mode, local rise alone with discOutSumLocal high → hitPulse, sumPulse and ack=4'hF in the same cycle; A=1, B=1. A repeat with ackFromNeighbour=4'b0001 → no pulses, A and B unchanged.
- Summing mode, simultaneous rise with discOutNeighbour[3] → no claim. Simultaneous rise with discOutNeighbour[0] only → claim.
- Counter at 4095 (CNT_W=12) plus 3 hits → stays 4095.
- A=12'hA5C, shutterA=0, SerInA=0 for 12 clocks → SerOutA bit sequence 1,0,1,0,0,1,0,1,1,1,0,0 (MSB first); A=0 afterwards. B keeps counting meanwhile with shutterB=1.
